instruction_loader: RTL and testbench

- Write-side counterpart of the 37-bit instruction memory.
- Accepts a byte stream from a host or debug link over a valid/ready handshake.
- Packs every 5 bytes into one 37-bit instruction and issues single-cycle write strobes to the memory write port at sequential addresses.
- Used to load a program before the core is released from reset.

---
 rtl/instruction_loader.sv | 168 ++++++++++++++++
 tb/tb_instruction_loader.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// ---------------------------------------------------------------------------
// instruction_loader
//
// Write-side loader for the 37-bit instruction memory. A host or debug link
// streams program bytes over a valid/ready handshake. Every BYTES_PER_WORD
// bytes are packed little-endian into one instruction, which is written to
// the memory with a single-cycle strobe at sequential addresses. It is used
// to load a program while the core is still held in reset.
//
// Ports
//   clk              system clock, all logic on the rising edge
//   reset            synchronous, active-high reset
//   start            one-cycle pulse that opens a session (honoured in IDLE)
//   start_address    first memory address written, captured on start
//   word_count       instructions to load (0..1024, larger values clamp)
//   byte_in          incoming program byte
//   byte_valid       byte_in is valid this cycle
//   byte_ready       loader accepts byte_in this cycle
//   mem_write_enable one-cycle write strobe to the instruction memory
//   mem_address      write address (holds between strobes)
//   mem_write_data   instruction to write (holds between strobes)
//   busy             session in progress (receiving or writing)
//   done             one-cycle pulse when the session ends
//   error            sticky format error, cleared by the next start or reset
// ---------------------------------------------------------------------------
module instruction_loader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int INSTR_WIDTH    = 37,
    parameter int BYTES_PER_WORD = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  start_address,
    input  logic [ADDR_WIDTH:0]    word_count,
    input  logic [7:0]             byte_in,
    input  logic                   byte_valid,
    output logic                   byte_ready,
    output logic                   mem_write_enable,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    output logic [INSTR_WIDTH-1:0] mem_write_data,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    // Bits supplied by the full bytes, and the few bits taken from the last one.
    localparam int LOW_BITS = 8 * (BYTES_PER_WORD - 1);
    localparam int TOP_BITS = INSTR_WIDTH - LOW_BITS;
    localparam int IDX_W    = $clog2(BYTES_PER_WORD);

    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_WORD  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECEIVE,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;        // index of the next byte within the word
    logic [LOW_BITS-1:0]   r_asm;        // full bytes of the word being assembled
    logic [ADDR_WIDTH-1:0] r_addr;       // address of the word being assembled
    logic [ADDR_WIDTH:0]   r_remaining;  // words still to be written

    logic [ADDR_WIDTH:0]   w_clamped_count;
    logic [INSTR_WIDTH-1:0] w_word;
    logic                  w_format_err;

    // A full memory's worth is the most a session can ever write.
    assign w_clamped_count = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;

    // The last byte completes the word directly, so the write strobe can
    // follow its handshake by exactly one cycle.
    assign w_word       = {byte_in[TOP_BITS-1:0], r_asm};
    assign w_format_err = |byte_in[7:TOP_BITS];

    // NOTE: every register in this block is assigned with <= so all of them
    // update together from the values seen at the same clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_idx            <= '0;
            r_asm            <= '0;
            r_addr           <= '0;
            r_remaining      <= '0;
            byte_ready       <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= start_address;
                        r_remaining <= w_clamped_count;
                        r_idx       <= '0;
                        error       <= 1'b0;
                        if (word_count == '0) begin
                            r_state <= S_FINISH;
                            done    <= 1'b1;
                        end else begin
                            r_state    <= S_RECEIVE;
                            byte_ready <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end
                end

                S_RECEIVE: begin
                    if (byte_valid && byte_ready) begin
                        if (r_idx == LAST_IDX) begin
                            // Upper bits of the last byte are dropped, but
                            // a non-zero value flags a malformed stream.
                            if (w_format_err) begin
                                error <= 1'b1;
                            end
                            mem_write_data   <= w_word;
                            mem_address      <= r_addr;
                            mem_write_enable <= 1'b1;
                            byte_ready       <= 1'b0;
                            r_state          <= S_WRITE;
                        end else begin
                            for (int k = 0; k < BYTES_PER_WORD - 1; k++) begin
                                if (r_idx == IDX_W'(k)) begin
                                    r_asm[8*k +: 8] <= byte_in;
                                end
                            end
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end

                S_WRITE: begin
                    mem_write_enable <= 1'b0;
                    // Address wraps naturally at the top of memory.
                    r_addr           <= r_addr + 1'b1;
                    r_remaining      <= r_remaining - 1'b1;
                    if (r_remaining == ONE_WORD) begin
                        r_state <= S_FINISH;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_state    <= S_RECEIVE;
                        r_idx      <= '0;
                        byte_ready <= 1'b1;
                    end
                end

                S_FINISH: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// ---------------------------------------------------------------------------
// tb_instruction_loader
//
// Self-checking bench for instruction_loader. A driver task runs one load
// session (random or steady byte_valid) and records what the memory port,
// handshake and status outputs did. Each scenario task compares those
// records against expectations computed from the byte stream it generated.
// ---------------------------------------------------------------------------
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  start_address;
    logic [10:0] word_count;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_write_enable;
    logic [9:0]  mem_address;
    logic [36:0] mem_write_data;
    logic        busy;
    logic        done;
    logic        error;

    instruction_loader dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .start_address    (start_address),
        .word_count       (word_count),
        .byte_in          (byte_in),
        .byte_valid       (byte_valid),
        .byte_ready       (byte_ready),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Byte stream for the current session and what the driver observed.
    logic [7:0]  tx_bytes[$];
    logic [9:0]  obs_addr[$];
    logic [36:0] obs_data[$];
    int          obs_we_cyc[$];
    int          acc_cyc[$];
    int          start_cyc, done_cyc, ready_in_write, busy_low, ready_seen;
    bit          timed_out;
    logic        err_at_done, busy_at_done;

    // ---------------- reference model ----------------
    function automatic logic [36:0] pack_word(input int w);
        logic [7:0] b4;
        b4 = tx_bytes[5*w+4];
        return {b4[4:0], tx_bytes[5*w+3], tx_bytes[5*w+2], tx_bytes[5*w+1], tx_bytes[5*w]};
    endfunction

    function automatic logic expect_error(input int nwords);
        logic [7:0] b4;
        for (int w = 0; w < nwords; w++) begin
            b4 = tx_bytes[5*w+4];
            if (b4[7:5] != 3'b000) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [9:0] expect_addr(input int base, input int i);
        return 10'((base + i) % 1024);
    endfunction

    task automatic fill_random(input int nbytes, input bit clean_top);
        tx_bytes.delete();
        for (int i = 0; i < nbytes; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (clean_top && (i % 5 == 4)) b[7:5] = 3'b000;
            tx_bytes.push_back(b);
        end
    endtask

    // ---------------- driver / recorder ----------------
    task automatic run_session(input logic [9:0] addr, input logic [10:0] wc,
                               input bit rand_valid, input int abort_after,
                               input int restart_at);
        int  bi = 0;
        bit  restarted = 0;
        int  budget;
        obs_addr.delete(); obs_data.delete(); obs_we_cyc.delete(); acc_cyc.delete();
        done_cyc = -1; ready_in_write = 0; busy_low = 0; ready_seen = 0;
        timed_out = 1; err_at_done = 1'bx; busy_at_done = 1'bx;
        budget = 8 * tx_bytes.size() + 50;

        @(posedge clk); #1;
        start = 1'b1; start_address = addr; word_count = wc;
        @(posedge clk); #1;
        start_cyc = cyc;
        for (int n = 0; n < budget; n++) begin
            start = 1'b0;
            if (restart_at >= 0 && !restarted && bi == restart_at) begin
                start = 1'b1; start_address = ~addr; word_count = 11'd5; restarted = 1;
            end
            if (bi < tx_bytes.size()) begin
                byte_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                byte_in    = tx_bytes[bi];
            end else begin
                byte_valid = 1'b0;
                byte_in    = 8'h00;
            end
            @(negedge clk);
            if (mem_write_enable) begin
                obs_addr.push_back(mem_address);
                obs_data.push_back(mem_write_data);
                obs_we_cyc.push_back(cyc);
                if (byte_ready) ready_in_write++;
            end
            if (byte_ready) ready_seen++;
            if (!done && !busy) busy_low++;
            if (byte_valid && byte_ready) begin
                acc_cyc.push_back(cyc);
                bi++;
            end
            if (done) begin
                done_cyc = cyc; err_at_done = error; busy_at_done = busy;
                timed_out = 0; byte_valid = 1'b0; start = 1'b0;
                break;
            end
            if (abort_after >= 0 && bi == abort_after) begin
                timed_out = 0;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start_address = '0; word_count = '0;
        byte_in = '0; byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({byte_ready, mem_write_enable, busy, done, error} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {byte_ready, mem_write_enable, busy, done, error});
        end
        checks++;
        if (mem_address !== 10'h000 || mem_write_data !== 37'h0) begin
            errors++;
            $display("FAIL reset_bus: got addr=%h data=%h expected 0/0", mem_address, mem_write_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_single_word();
        tx_bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h1F};
        run_session(10'h010, 11'd1, 1'b0, -1, -1);
        checks++;
        if (timed_out || obs_addr.size() != 1) begin
            errors++;
            $display("FAIL single_count: got %0d strobes timeout=%0d expected 1", obs_addr.size(), timed_out);
        end else begin
            checks++;
            if (obs_addr[0] !== 10'h010 || obs_data[0] !== 37'h1F12345678) begin
                errors++;
                $display("FAIL single_write: got %h/%h expected 010/1f12345678", obs_addr[0], obs_data[0]);
            end
            // Steady valid: bytes in cycles 0..4 after start, strobe in the next.
            checks++;
            if (obs_we_cyc[0] != start_cyc + 5 || obs_we_cyc[0] != acc_cyc[4] + 1) begin
                errors++;
                $display("FAIL single_latency: got strobe cycle %0d expected %0d", obs_we_cyc[0], start_cyc + 5);
            end
            checks++;
            if (done_cyc != obs_we_cyc[0] + 1 || err_at_done !== 1'b0 || busy_at_done !== 1'b0) begin
                errors++;
                $display("FAIL single_done: got done cyc %0d err=%b busy=%b expected %0d 0 0",
                         done_cyc, err_at_done, busy_at_done, obs_we_cyc[0] + 1);
            end
        end
        checks++;
        if (mem_write_enable !== 1'b0 || mem_write_data !== 37'h1F12345678 || mem_address !== 10'h010) begin
            errors++;
            $display("FAIL single_hold: got we=%b %h/%h expected 0 010/1f12345678",
                     mem_write_enable, mem_address, mem_write_data);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: got done=%b busy=%b ready=%b expected 0 0 0", done, busy, byte_ready);
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        fill_random(15, 1'b1);
        run_session(10'h000, 11'd3, 1'b1, -1, -1);
        checks++;
        if (timed_out || obs_addr.size() != 3 || acc_cyc.size() != 15) begin
            errors++;
            $display("FAIL multi_count: got %0d strobes %0d bytes expected 3 15", obs_addr.size(), acc_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (obs_addr[i] !== expect_addr(0, i) || obs_data[i] !== pack_word(i)) bad++;
                if (obs_we_cyc[i] != acc_cyc[5*i+4] + 1) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL multi_writes: got %0d bad address/data/timing items expected 0", bad);
            end
            checks++;
            if (done_cyc != obs_we_cyc[2] + 1 || err_at_done !== expect_error(3)) begin
                errors++;
                $display("FAIL multi_done: got cyc %0d err=%b expected %0d err=%b",
                         done_cyc, err_at_done, obs_we_cyc[2] + 1, expect_error(3));
            end
        end
        checks++;
        if (ready_in_write != 0 || busy_low != 0) begin
            errors++;
            $display("FAIL multi_flags: got ready-in-write=%0d busy-low=%0d expected 0 0", ready_in_write, busy_low);
        end
    endtask

    task automatic test_wrap();
        fill_random(10, 1'b0);
        run_session(10'h3FF, 11'd2, 1'b1, -1, -1);
        checks++;
        if (timed_out || obs_addr.size() != 2) begin
            errors++;
            $display("FAIL wrap_count: got %0d strobes expected 2", obs_addr.size());
        end else begin
            checks++;
            if (obs_addr[0] !== expect_addr(1023, 0) || obs_addr[1] !== expect_addr(1023, 1)) begin
                errors++;
                $display("FAIL wrap_addr: got %h,%h expected 3ff,000", obs_addr[0], obs_addr[1]);
            end
            checks++;
            if (obs_data[0] !== pack_word(0) || obs_data[1] !== pack_word(1)) begin
                errors++;
                $display("FAIL wrap_data: got %h,%h expected %h,%h", obs_data[0], obs_data[1], pack_word(0), pack_word(1));
            end
            checks++;
            if (done_cyc != obs_we_cyc[1] + 1 || err_at_done !== expect_error(2)) begin
                errors++;
                $display("FAIL wrap_done: got cyc %0d err=%b expected %0d err=%b",
                         done_cyc, err_at_done, obs_we_cyc[1] + 1, expect_error(2));
            end
        end
    endtask

    task automatic test_format_error();
        fill_random(4, 1'b0);
        tx_bytes.push_back(8'hE5);
        run_session(10'h155, 11'd1, 1'b1, -1, -1);
        checks++;
        if (timed_out || obs_data.size() != 1) begin
            errors++;
            $display("FAIL fmt_count: got %0d strobes expected 1", obs_data.size());
        end else begin
            checks++;
            if (obs_data[0][36:32] !== 5'h05 || obs_data[0] !== pack_word(0)) begin
                errors++;
                $display("FAIL fmt_data: got %h expected %h", obs_data[0], pack_word(0));
            end
        end
        checks++;
        if (err_at_done !== 1'b1) begin
            errors++;
            $display("FAIL fmt_err_done: got %b expected 1", err_at_done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (error !== 1'b1) begin
            errors++;
            $display("FAIL fmt_err_sticky: got %b expected 1", error);
        end
        // A following start clears the flag.
        tx_bytes.delete();
        run_session(10'h000, 11'd0, 1'b0, -1, -1);
        checks++;
        if (timed_out || err_at_done !== 1'b0) begin
            errors++;
            $display("FAIL fmt_err_clear: got %b timeout=%0d expected 0", err_at_done, timed_out);
        end
    endtask

    task automatic test_zero_and_ignored_start();
        tx_bytes.delete();
        run_session(10'h2A0, 11'd0, 1'b0, -1, -1);
        checks++;
        if (timed_out || done_cyc != start_cyc || obs_addr.size() != 0 || ready_seen != 0) begin
            errors++;
            $display("FAIL zero_count: got done cyc %0d strobes %0d ready %0d expected %0d 0 0",
                     done_cyc, obs_addr.size(), ready_seen, start_cyc);
        end
        // Second start mid-session with another address and count.
        fill_random(10, 1'b1);
        run_session(10'h123, 11'd2, 1'b1, -1, 3);
        checks++;
        if (timed_out || obs_addr.size() != 2) begin
            errors++;
            $display("FAIL ign_count: got %0d strobes timeout=%0d expected 2", obs_addr.size(), timed_out);
        end else begin
            checks++;
            if (obs_addr[0] !== expect_addr(10'h123, 0) || obs_addr[1] !== expect_addr(10'h123, 1) ||
                obs_data[0] !== pack_word(0) || obs_data[1] !== pack_word(1)) begin
                errors++;
                $display("FAIL ign_writes: got %h/%h %h/%h expected 123/%h 124/%h",
                         obs_addr[0], obs_data[0], obs_addr[1], obs_data[1], pack_word(0), pack_word(1));
            end
        end
    endtask

    task automatic test_reset_mid();
        int strobes = 0;
        fill_random(15, 1'b1);
        run_session(10'h040, 11'd3, 1'b1, 8, -1);
        // The 8th byte is taken at this edge; reset lands on the following one.
        @(posedge clk); #1;
        reset = 1'b1; byte_valid = 1'b0;
        @(negedge clk);
        if (mem_write_enable) strobes++;
        @(negedge clk);
        checks++;
        if ({byte_ready, mem_write_enable, busy, done, error} !== 5'b0 ||
            mem_address !== 10'h000 || mem_write_data !== 37'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got flags=%b addr=%h data=%h expected 0",
                     {byte_ready, mem_write_enable, busy, done, error}, mem_address, mem_write_data);
        end
        checks++;
        if (obs_addr.size() != 1) begin
            errors++;
            $display("FAIL mid_first_word: got %0d strobes expected 1", obs_addr.size());
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (mem_write_enable) strobes++;
        end
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL mid_no_strobe: got %0d strobes expected 0", strobes);
        end
        fill_random(5, 1'b1);
        run_session(10'h041, 11'd1, 1'b1, -1, -1);
        checks++;
        if (timed_out || obs_addr.size() != 1 || obs_addr[0] !== 10'h041 || obs_data[0] !== pack_word(0)) begin
            errors++;
            $display("FAIL mid_resume: got %0d strobes timeout=%0d expected one write of %h at 041",
                     obs_addr.size(), timed_out, pack_word(0));
        end
    endtask

    task automatic test_clamp();
        int bad = 0;
        fill_random(5 * 1024, 1'b1);
        run_session(10'h200, 11'h7FF, 1'b0, -1, -1);
        checks++;
        if (timed_out || obs_addr.size() != 1024) begin
            errors++;
            $display("FAIL clamp_count: got %0d strobes timeout=%0d expected 1024", obs_addr.size(), timed_out);
        end else begin
            for (int i = 0; i < 1024; i++) begin
                if (obs_addr[i] !== expect_addr(10'h200, i) || obs_data[i] !== pack_word(i)) bad++;
            end
            checks++;
            if (bad != 0 || done_cyc != obs_we_cyc[1023] + 1) begin
                errors++;
                $display("FAIL clamp_writes: got %0d bad writes done cyc %0d expected 0 %0d",
                         bad, done_cyc, obs_we_cyc[1023] + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_wrap();
        test_format_error();
        test_zero_and_ignored_start();
        test_reset_mid();
        test_clamp();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
